fstore_tty: RTL and testbench
=============================

FSTORE_TTY -- requirements
Module: fstore_tty

Interface
REQ-001 SHALL have parameter COLS, default 128, meaning visible text columns (multiple of 4, range 4..128).
REQ-002 SHALL have parameter ROWS, default 32, meaning visible text rows (range 2..64).
REQ-003 SHALL have parameter DEF_ATTR, default 8'h0F, meaning the attribute byte used for the post-reset clear.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports as below.
- clk_i  input  1  clock; all logic is on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- ch_valid  input  1  byte offered.
- ch_data  input  8  byte code; held stable while ch_valid=1 and ch_ready=0.
- attr_i  input  8  cell attribute {graph, bg[2:0], fg[3:0]}; sampled on acceptance.
- ch_ready  output  1  block accepts a byte this cycle.
- busy  output  1  inverse of ch_ready.
- hid_en  output  1  bus access strobe, one cycle per access.
- hid_we  output  8  byte write enables; all zero means read.
- hid_addr  output  19  byte address; bits [2:0] are always 0.
- hid_wrdata  output  64  write data.
- one_hot_data_addr  output  8  8'h80 while hid_en=1, else 8'h00.
- hid_rddata  input  64  framebuffer read data, valid in the cycle after a read strobe.
- cur_x  output  7  current cursor column.
- cur_y  output  6  current cursor row.

Function
REQ-005 SHALL register every output.
REQ-006 SHALL format a text cell as 16 bits {attr, ch}; one 64-bit word holds 4 cells.
- Word address hid_addr[13:3] = {row[5:0], col[6:2]}.
- hid_addr[18:14] = 0.
REQ-007 SHALL write a single cell with hid_wrdata = cell replicated 4x and hid_we = 8'b11 << (2*col[1:0]).
REQ-008 SHALL write cursor registers at hid_addr = 19'h4000 | (idx<<3), with hid_we = 8'hFF and zero-extended data.
- idx 2 = cur_x.
- idx 3 = cur_y.
REQ-009 SHALL accept a byte on any rising edge where ch_valid=1 and ch_ready=1; ch_ready SHALL be 1 only in state IDLE.
REQ-010 SHALL implement states RST_CLR, IDLE, PUT, CTRL, SCR_RD, SCR_CAP, SCR_WR, ROW_CLR, SCR_CLR, CUR_X, CUR_Y.
REQ-011 SHALL, for printable bytes (0x20..0xFF except 0x7F), go IDLE->PUT.
- Write the cell at (cur_x, cur_y).
- cur_x+1; if the result equals COLS, apply newline.
- Then CUR_X->CUR_Y->IDLE.
- ch_ready returns 4 cycles after acceptance when no scroll occurs.
REQ-012 SHALL handle control bytes via CTRL (no bus access), then CUR_X->CUR_Y->IDLE; ch_ready returns 4 cycles after acceptance.
- 0x0D: cur_x=0.
- 0x0A: newline.
- 0x08: cur_x-1, saturating at 0, no erase.
- 0x0C: clear screen, then cur_x=cur_y=0.
- Any other code: no effect.
REQ-013 SHALL define newline as cur_x=0 plus one of:
- if cur_y<ROWS-1, cur_y+1;
- else cur_y unchanged and scroll.
REQ-014 SHALL scroll as follows, copying 3 cycles per word.
- For w = 0..(ROWS-1)*32-1 in ascending order:
  - SCR_RD: read word w+32.
  - SCR_CAP: idle bus, capture hid_rddata.
  - SCR_WR: write captured data to word w with hid_we=8'hFF.
- Then ROW_CLR: 32 single-cycle writes of {attr,8'h20}x4 to row ROWS-1, where attr is the attribute latched at acceptance.
REQ-015 SHALL clear the screen (SCR_CLR) with ROWS*32 consecutive single-cycle full-word writes of {attr,8'h20}x4, word 0 upward.
REQ-016 SHALL ignore ch_valid while ch_ready=0; no byte is lost or duplicated.
REQ-017 SHALL hold hid_en=0 in IDLE, CTRL and SCR_CAP.

Reset
REQ-018 SHALL, while rst_ni=0, force these values:
- ch_ready=0, busy=1;
- hid_en=0, hid_we=0, hid_addr=0, hid_wrdata=0;
- one_hot_data_addr=0;
- cur_x=0, cur_y=0;
- state RST_CLR.
REQ-019 SHALL, after reset release, run a full screen clear using DEF_ATTR, then CUR_X, CUR_Y, then IDLE.
REQ-020 SHALL abandon any operation in progress, including a scroll, on reset assertion and restart per REQ-019.

Verification
REQ-021 Reset release -> 1024 writes of 64'h0F20_0F20_0F20_0F20 (words 0..1023), cursor writes x=0 and y=0, ch_ready=1 on cycle 1027.
REQ-022 'A' (0x41), attr 8'h1E, at (5,2) -> one write: hid_addr=19'h0208, hid_we=8'h0C, hid_wrdata=64'h1E41_1E41_1E41_1E41; then cur_x=6; ch_ready 4 cycles later.
REQ-023 0x41 at (127,31) -> cell write, then scroll: 2976 copy cycles plus 32 clear writes; final cur_x=0, cur_y=31; ch_ready 3012 cycles after acceptance.
REQ-024 Stream 0x0D, 0x08, 0x07 at (0,0) with ch_valid held high -> each byte accepted exactly once, 4 cycles apart; cursor stays (0,0); no cell writes.
REQ-025 rst_ni pulsed low mid-scroll -> outputs take the REQ-018 values immediately, then the REQ-021 sequence.
REQ-026 0x0C at (9,9) -> 1024 clear writes using the latched attribute, then cur_x=0, cur_y=0.

Source files
------------

// File: rtl/fstore_tty.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fstore_tty -- character terminal front end for a 64-bit framebuffer.
//
// Accepts one byte at a time, writes printable characters as 16-bit cells
// {attr, ch} into a text framebuffer (4 cells per 64-bit word, 32 words per
// row), interprets CR/LF/BS/FF, scrolls the screen by copying words upward,
// and publishes the cursor position through two register writes after every
// byte. A full-screen clear runs after every reset release.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   ch_valid/ch_data   byte offer; accepted when ch_valid && ch_ready
//   attr_i             cell attribute, sampled together with the byte
//   ch_ready, busy     ready for a byte / its inverse
//   hid_en             one-cycle bus access strobe
//   hid_we             byte write enables (all zero = read)
//   hid_addr           byte address, 8-byte aligned
//   hid_wrdata         write data
//   one_hot_data_addr  8'h80 while hid_en is high
//   hid_rddata         read data, valid the cycle after a read strobe
//   cur_x, cur_y       current cursor column / row
// -----------------------------------------------------------------------------
module fstore_tty #(
  parameter int         COLS     = 128,
  parameter int         ROWS     = 32,
  parameter logic [7:0] DEF_ATTR = 8'h0F
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  input  logic [7:0]  attr_i,
  output logic        ch_ready,
  output logic        busy,
  output logic        hid_en,
  output logic [7:0]  hid_we,
  output logic [18:0] hid_addr,
  output logic [63:0] hid_wrdata,
  output logic [7:0]  one_hot_data_addr,
  input  logic [63:0] hid_rddata,
  output logic [6:0]  cur_x,
  output logic [5:0]  cur_y
);

  typedef enum logic [3:0] {
    RST_CLR, IDLE, PUT, CTRL, SCR_RD, SCR_CAP, SCR_WR,
    ROW_CLR, SCR_CLR, CUR_X, CUR_Y
  } state_t;

  localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);
  localparam logic [11:0] CLR_LAST   = 12'(ROWS * 32 - 1);
  localparam logic [11:0] SCR_LAST   = 12'((ROWS - 1) * 32 - 1);
  localparam logic [18:0] CUR_X_ADDR = 19'h4010;  // register index 2
  localparam logic [18:0] CUR_Y_ADDR = 19'h4018;  // register index 3
  localparam logic [7:0]  CH_SPACE   = 8'h20;
  localparam logic [7:0]  CH_BS      = 8'h08;
  localparam logic [7:0]  CH_LF      = 8'h0A;
  localparam logic [7:0]  CH_FF      = 8'h0C;
  localparam logic [7:0]  CH_CR      = 8'h0D;
  localparam logic [7:0]  CH_DEL     = 8'h7F;

  state_t      state;
  logic [11:0] cnt;      // word counter for clear / scroll loops
  logic [7:0]  ch_q;     // byte latched at acceptance
  logic [7:0]  attr_q;   // attribute latched at acceptance (DEF_ATTR after reset)

  logic        bus_en;
  logic [7:0]  bus_we;
  logic [18:0] bus_addr;
  logic [63:0] bus_wd;
  logic [10:0] src_word;
  logic        is_print;
  logic        newline;

  function automatic logic [18:0] word_addr(input logic [10:0] w);
    return {5'd0, w, 3'b000};
  endfunction

  assign src_word = cnt[10:0] + 11'd32;  // scroll source: one row below
  assign is_print = (ch_data >= CH_SPACE) && (ch_data != CH_DEL);
  assign newline  = ((state == PUT)  && (cur_x == LAST_COL)) ||
                    ((state == CTRL) && (ch_q == CH_LF));

  // Bus action issued by the current state; registered below.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    bus_en   = 1'b0;
    bus_we   = 8'h00;
    bus_addr = hid_addr;
    bus_wd   = hid_wrdata;
    case (state)
      RST_CLR, SCR_CLR: begin
        bus_en   = 1'b1;
        bus_we   = 8'hFF;
        bus_addr = word_addr(cnt[10:0]);
        bus_wd   = {4{attr_q, CH_SPACE}};
      end
      PUT: begin
        bus_en   = 1'b1;
        bus_we   = 8'b0000_0011 << {cur_x[1:0], 1'b0};
        bus_addr = word_addr({cur_y, cur_x[6:2]});
        bus_wd   = {4{attr_q, ch_q}};
      end
      SCR_RD: begin
        bus_en   = 1'b1;
        bus_addr = word_addr(src_word);
      end
      SCR_WR: begin
        // The read issued two cycles ago returns its data during the idle
        // SCR_CAP bus cycle; it is registered straight into the write data.
        bus_en   = 1'b1;
        bus_we   = 8'hFF;
        bus_addr = word_addr(cnt[10:0]);
        bus_wd   = hid_rddata;
      end
      ROW_CLR: begin
        bus_en   = 1'b1;
        bus_we   = 8'hFF;
        bus_addr = word_addr({LAST_ROW, cnt[4:0]});
        bus_wd   = {4{attr_q, CH_SPACE}};
      end
      CUR_X: begin
        bus_en   = 1'b1;
        bus_we   = 8'hFF;
        bus_addr = CUR_X_ADDR;
        bus_wd   = {57'd0, cur_x};
      end
      CUR_Y: begin
        bus_en   = 1'b1;
        bus_we   = 8'hFF;
        bus_addr = CUR_Y_ADDR;
        bus_wd   = {58'd0, cur_y};
      end
      default: ;  // IDLE, CTRL, SCR_CAP keep the bus quiet
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= RST_CLR;
      cnt               <= '0;
      ch_q              <= '0;
      attr_q            <= DEF_ATTR;
      ch_ready          <= 1'b0;
      busy              <= 1'b1;
      hid_en            <= 1'b0;
      hid_we            <= '0;
      hid_addr          <= '0;
      hid_wrdata        <= '0;
      one_hot_data_addr <= '0;
      cur_x             <= '0;
      cur_y             <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read in
      // this block sees the pre-edge value; where the same register is
      // assigned twice, the later assignment wins (used by newline below).
      hid_en            <= bus_en;
      hid_we            <= bus_we;
      hid_addr          <= bus_addr;
      hid_wrdata        <= bus_wd;
      one_hot_data_addr <= bus_en ? 8'h80 : 8'h00;
      ch_ready          <= 1'b0;
      busy              <= 1'b1;

      case (state)
        RST_CLR, SCR_CLR: begin
          if (cnt == CLR_LAST) begin
            cnt   <= '0;
            state <= CUR_X;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        IDLE: begin
          if (ch_valid && ch_ready) begin
            ch_q   <= ch_data;
            attr_q <= attr_i;
            state  <= is_print ? PUT : CTRL;
          end else begin
            ch_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        PUT: begin
          cur_x <= cur_x + 7'd1;
          state <= CUR_X;
        end
        CTRL: begin
          state <= CUR_X;
          case (ch_q)
            CH_CR: cur_x <= '0;
            CH_BS: if (cur_x != 7'd0) cur_x <= cur_x - 7'd1;
            CH_FF: begin
              cur_x <= '0;
              cur_y <= '0;
              cnt   <= '0;
              state <= SCR_CLR;
            end
            default: ;  // LF handled below, others ignored
          endcase
        end
        SCR_RD:  state <= SCR_CAP;
        SCR_CAP: state <= SCR_WR;
        SCR_WR: begin
          if (cnt == SCR_LAST) begin
            cnt   <= '0;
            state <= ROW_CLR;
          end else begin
            cnt   <= cnt + 12'd1;
            state <= SCR_RD;
          end
        end
        ROW_CLR: begin
          if (cnt[4:0] == 5'd31) begin
            cnt   <= '0;
            state <= CUR_X;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        CUR_X:   state <= CUR_Y;
        CUR_Y:   state <= IDLE;
        default: state <= IDLE;
      endcase

      // Newline overrides the column/next-state chosen above.
      if (newline) begin
        cur_x <= '0;
        if (cur_y == LAST_ROW) begin
          cnt   <= '0;
          state <= SCR_RD;
        end else begin
          cur_y <= cur_y + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fstore_tty.sv
`timescale 1ns/1ps
module tb_fstore_tty;
  localparam int COLS       = 128;
  localparam int ROWS       = 32;
  localparam int WORDS      = ROWS * 32;
  localparam int SCROLL_CYC = (ROWS - 1) * 32 * 3 + 32;

  logic        clk_i    = 1'b0;
  logic        rst_ni   = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data  = 8'h00;
  logic [7:0]  attr_i   = 8'h00;
  logic        ch_ready, busy, hid_en;
  logic [7:0]  hid_we;
  logic [18:0] hid_addr;
  logic [63:0] hid_wrdata;
  logic [7:0]  one_hot_data_addr;
  logic [63:0] hid_rddata = 64'd0;
  logic [6:0]  cur_x;
  logic [5:0]  cur_y;

  fstore_tty #(.COLS(COLS), .ROWS(ROWS), .DEF_ATTR(8'h0F)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .ch_valid          (ch_valid),
    .ch_data           (ch_data),
    .attr_i            (attr_i),
    .ch_ready          (ch_ready),
    .busy              (busy),
    .hid_en            (hid_en),
    .hid_we            (hid_we),
    .hid_addr          (hid_addr),
    .hid_wrdata        (hid_wrdata),
    .one_hot_data_addr (one_hot_data_addr),
    .hid_rddata        (hid_rddata),
    .cur_x             (cur_x),
    .cur_y             (cur_y)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  we;
    logic [18:0] addr;
    logic [63:0] data;
    bit          chk_data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        mon_e;
  logic [63:0] exp_mem [WORDS];   // expected screen contents
  logic [63:0] fb      [2048];    // framebuffer the DUT actually talks to
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mx = 0, my = 0;    // model cursor
  int          last_lat = 0;
  int          dummy_lat;
  logic [18:0] last_cell_addr = '0;
  logic [7:0]  last_cell_we   = '0;
  logic [63:0] last_cell_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Framebuffer: byte-enabled writes, read data one cycle after the strobe.
  always @(posedge clk_i) begin : fb_proc
    logic [10:0] w;
    w = hid_addr[13:3];
    if (hid_en && hid_addr[18:14] == 5'd0) begin
      if (hid_we == 8'h00) begin
        #1 hid_rddata = fb[w];
      end else begin
        for (int b = 0; b < 8; b++)
          if (hid_we[b]) fb[w][8*b +: 8] = hid_wrdata[8*b +: 8];
      end
    end
  end

  // Monitor: every bus strobe is matched against the next expected access.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("busy_vs_ready", 64'(busy), 64'(!ch_ready));
      if (hid_en) begin
        check("one_hot_on", 64'(one_hot_data_addr), 64'h80);
        if (hid_we != 8'h00 && hid_we != 8'hFF) begin
          last_cell_addr = hid_addr;
          last_cell_we   = hid_we;
          last_cell_data = hid_wrdata;
        end
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_access: got addr %h we %h, required no access", hid_addr, hid_we);
        end else begin
          mon_e = exp_q.pop_front();
          check("acc_addr", 64'(hid_addr), 64'(mon_e.addr));
          check("acc_we", 64'(hid_we), 64'(mon_e.we));
          if (mon_e.chk_data) check("acc_data", hid_wrdata, mon_e.data);
        end
      end else begin
        check("one_hot_off", 64'(one_hot_data_addr), 64'h0);
      end
    end
  end

  function automatic logic [18:0] waddr(input int w);
    return 19'(w * 8);
  endfunction

  task automatic push_write(input logic [18:0] addr, input logic [7:0] we, input logic [63:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data; t.chk_data = 1'b1;
    exp_q.push_back(t);
    if (addr[18:14] == 5'd0)
      for (int b = 0; b < 8; b++)
        if (we[b]) exp_mem[int'(addr[13:3])][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic push_read(input logic [18:0] addr);
    txn_t t;
    t.we = 8'h00; t.addr = addr; t.data = '0; t.chk_data = 1'b0;
    exp_q.push_back(t);
  endtask

  task automatic model_newline(input logic [7:0] a, inout int lat);
    mx = 0;
    if (my < ROWS - 1) begin
      my++;
    end else begin
      for (int w = 0; w < (ROWS - 1) * 32; w++) begin
        push_read(waddr(w + 32));
        push_write(waddr(w), 8'hFF, exp_mem[w + 32]);
      end
      for (int c = 0; c < 32; c++)
        push_write(waddr((ROWS - 1) * 32 + c), 8'hFF, {4{a, 8'h20}});
      lat += SCROLL_CYC;
    end
  endtask

  // Terminal behaviour model: queues the expected bus accesses for one byte
  // and returns the expected acceptance-to-ready latency.
  task automatic model(input logic [7:0] c, input logic [7:0] a, output int lat);
    logic [7:0] we;
    lat = 4;
    if (c >= 8'h20 && c != 8'h7F) begin
      we = 8'h03 << (2 * (mx % 4));
      push_write(waddr(my * 32 + mx / 4), we, {4{a, c}});
      mx++;
      if (mx == COLS) model_newline(a, lat);
    end else begin
      case (c)
        8'h0D: mx = 0;
        8'h0A: model_newline(a, lat);
        8'h08: if (mx > 0) mx--;
        8'h0C: begin
          for (int w = 0; w < WORDS; w++) push_write(waddr(w), 8'hFF, {4{a, 8'h20}});
          mx = 0;
          my = 0;
          lat += WORDS;
        end
        default: ;
      endcase
    end
    push_write(19'h4010, 8'hFF, 64'(mx));
    push_write(19'h4018, 8'hFF, 64'(my));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ch_ready && n < 5000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!ch_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: ch_ready %0b, required 1", ch_ready);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int lat, exp_lat;
    wait_ready();
    model(c, a, exp_lat);
    ch_data = c; attr_i = a; ch_valid = 1'b1;
    @(posedge clk_i); #1;
    ch_valid = 1'b0;
    lat = 0;
    while (!ch_ready && lat < 5000) begin
      @(posedge clk_i); #1;
      lat++;
    end
    last_lat = lat;
    check("ready_latency", 64'(lat), 64'(exp_lat));
    check("cur_x", 64'(cur_x), 64'(mx));
    check("cur_y", 64'(cur_y), 64'(my));
  endtask

  task automatic check_reset_outputs();
    check("rst_ch_ready", 64'(ch_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_hid_en", 64'(hid_en), 64'd0);
    check("rst_hid_we", 64'(hid_we), 64'd0);
    check("rst_hid_addr", 64'(hid_addr), 64'd0);
    check("rst_hid_wrdata", hid_wrdata, 64'd0);
    check("rst_one_hot", 64'(one_hot_data_addr), 64'd0);
    check("rst_cur_x", 64'(cur_x), 64'd0);
    check("rst_cur_y", 64'(cur_y), 64'd0);
  endtask

  task automatic do_reset();
    int cyc;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs();
    mx = 0;
    my = 0;
    for (int w = 0; w < WORDS; w++) push_write(waddr(w), 8'hFF, {4{16'h0F20}});
    push_write(19'h4010, 8'hFF, 64'd0);
    push_write(19'h4018, 8'hFF, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc = 0;
    while (!ch_ready && cyc < 2000) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("rst_ready_cycle", 64'(cyc), 64'd1027);
    check("rst_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // CR, BS, BEL streamed with ch_valid held high: each accepted once, with
  // ch_ready low for 4 cycles between consecutive acceptances.
  task automatic stream3();
    logic [7:0] seq [3] = '{8'h0D, 8'h08, 8'h07};
    int   idx, cyc, last;
    logic rdy;
    idx = 0; cyc = 0; last = 0;
    wait_ready();
    for (int i = 0; i < 3; i++) model(seq[i], 8'h0F, dummy_lat);
    ch_data = seq[0]; attr_i = 8'h0F; ch_valid = 1'b1;
    while (idx < 3 && cyc < 100) begin
      rdy = ch_ready;
      @(posedge clk_i); #1;
      cyc++;
      if (rdy) begin
        if (idx > 0) check("stream_busy_gap", 64'(cyc - last - 1), 64'd4);
        last = cyc;
        idx++;
        if (idx < 3) ch_data = seq[idx];
      end
    end
    ch_valid = 1'b0;
    check("stream_accepted", 64'(idx), 64'd3);
    wait_ready();
    check("stream_cur_x", 64'(cur_x), 64'd0);
    check("stream_cur_y", 64'(cur_y), 64'd0);
    check("stream_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();
    stream3();

    // 'A' with attr 1E at (5,2)
    repeat (2) send(8'h0A, 8'h0F);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 8'h0F);
    send(8'h41, 8'h1E);
    check("A_addr", 64'(last_cell_addr), 64'h0208);
    check("A_we", 64'(last_cell_we), 64'h0C);
    check("A_data", last_cell_data, 64'h1E41_1E41_1E41_1E41);
    check("A_cur_x", 64'(cur_x), 64'd6);

    send(8'h08, 8'h0F);
    check("bs_cur_x", 64'(cur_x), 64'd5);
    send(8'h0D, 8'h0F);
    repeat (29) send(8'h0A, 8'h0F);
    for (int i = 0; i < 127; i++) send(8'h61 + 8'(i % 26), 8'h70 | 8'(i % 16));

    // 'A' at (127,31): cell write then full scroll
    send(8'h41, 8'h1E);
    check("scroll_lat", 64'(last_lat), 64'd3012);
    check("scroll_cur_x", 64'(cur_x), 64'd0);
    check("scroll_cur_y", 64'(cur_y), 64'd31);
    check("scrolled_word", fb[33], 64'h0F20_0F20_1E41_0F34);
    check("cleared_row", fb[1023], 64'h1E20_1E20_1E20_1E20);

    // LF on the last row starts another scroll; reset lands in the middle
    wait_ready();
    model(8'h0A, 8'h0F, dummy_lat);
    ch_data = 8'h0A; attr_i = 8'h0F; ch_valid = 1'b1;
    @(posedge clk_i); #1;
    ch_valid = 1'b0;
    repeat (500) @(posedge clk_i);
    #1;
    check("mid_scroll_busy", 64'(busy), 64'd1);
    do_reset();

    // FF at (9,9) with attr 2A
    repeat (9) send(8'h0A, 8'h0F);
    for (int i = 0; i < 9; i++) send(8'h78, 8'h0F);
    check("pos_cur_x", 64'(cur_x), 64'd9);
    check("pos_cur_y", 64'(cur_y), 64'd9);
    send(8'h0C, 8'h2A);
    check("ff_lat", 64'(last_lat), 64'd1028);
    check("ff_word0", fb[0], 64'h2A20_2A20_2A20_2A20);
    check("ff_word_last", fb[1023], 64'h2A20_2A20_2A20_2A20);
    check("ff_cur_x", 64'(cur_x), 64'd0);
    check("ff_cur_y", 64'(cur_y), 64'd0);

    repeat (4) @(posedge clk_i);
    #1;
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
